// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared state encoding and next-PC select constants for pc_ctrl
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MULT = 2'd2
    } state_e;

    // Next-PC mux select codes, also used by the ID-stage next-PC mux.
    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    // Wide enough for the largest legal multiply latency (15).
    localparam int MUL_CNT_W = 4;

endpackage

// File: rtl/pc_ctrl_sat_counter.sv
// rtl/pc_ctrl_sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - per-cycle PC update / IF-ID / ID-EX / freeze decision for the 5-stage pipe
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             ld_use_hazard_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_stall_i,
    input  logic             mult_start_i,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             freeze_o,
    output logic             mult_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_e               state_q;
    state_e               state_d;
    logic [MUL_CNT_W-1:0] mcnt_q;
    logic [MUL_CNT_W-1:0] mcnt_d;
    logic                 run_rules;
    logic                 stall_en;

    always_comb begin
        pc_we_o        = 1'b0;
        pc_sel_o       = PC_SEL_SEQ;
        if_id_we_o     = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        freeze_o       = 1'b0;
        mult_busy_o    = (state_q == ST_MULT);
        state_d        = state_q;
        mcnt_d         = mcnt_q;
        run_rules      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                freeze_o = 1'b1;
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mem_stall_i) begin
                    freeze_o = 1'b1;
                end else if (mult_start_i) begin
                    freeze_o = 1'b1;
                    mcnt_d   = MUL_CNT_W'(MUL_LATENCY - 1);
                    state_d  = ST_MULT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MULT: begin
                if (mcnt_q != '0) begin
                    freeze_o = 1'b1;
                    mcnt_d   = mcnt_q - MUL_CNT_W'(1);
                end else if (mem_stall_i) begin
                    freeze_o = 1'b1;
                end else begin
                    run_rules = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                freeze_o = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase

        // Hazard/redirect priority shared by RUN and the MULT release cycle.
        if (run_rules) begin
            if (ld_use_hazard_i) begin
                id_ex_bubble_o = 1'b1;
            end else if (jump_i) begin
                pc_we_o       = 1'b1;
                pc_sel_o      = PC_SEL_JUMP;
                if_id_flush_o = 1'b1;
            end else if (branch_taken_i) begin
                pc_we_o       = 1'b1;
                pc_sel_o      = PC_SEL_BRANCH;
                if_id_flush_o = 1'b1;
            end else begin
                pc_we_o    = 1'b1;
                if_id_we_o = 1'b1;
            end
        end

        // Dropping start overrides the next state but not this cycle's outputs.
        if ((state_q != ST_IDLE) && !start_i) begin
            state_d = ST_IDLE;
            mcnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign stall_en = (state_q != ST_IDLE) && !pc_we_o;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .en_i   (stall_en),
        .cnt_o  (stall_cnt_o)
    );

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Pipeline sequencing controller that owns the program-counter update and the IF/ID / ID/EX / pipeline-wide control strobes of the 5-stage CPU. It merges start/idle control, load-use hazards, branch and jump redirects, data-memory stalls and a multi-cycle multiplier stall into one prioritised decision per cycle. It drives the PC write enable and next-PC mux select, and keeps a saturating stall-cycle performance counter.

## Interface
- MUL_LATENCY, 3, total freeze cycles for a multiply in EX; legal range 1–15
- CNT_W, 32, stall counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  CPU run enable; low = hold everything
- ld_use_hazard_i  in  1  ID/EX load whose rt matches a source of the ID instruction
- branch_taken_i  in  1  branch resolved taken in ID
- jump_i  in  1  jump decoded in ID
- mem_stall_i  in  1  data memory not ready (level)
- mult_start_i  in  1  multiply instruction present in EX
- pc_we_o  out  1  PC register load enable
- pc_sel_o  out  2  next PC: 00 = PC+4, 01 = branch target, 10 = jump target
- if_id_we_o  out  1  IF/ID register write enable
- if_id_flush_o  out  1  clear IF/ID to NOP
- id_ex_bubble_o  out  1  insert NOP into ID/EX
- freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- mult_busy_o  out  1  high in MULT state
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_we_o = 0 while running

## Operation
- States: IDLE, RUN, MULT. Reset → IDLE, stall counter 0.
- IDLE: pc_we_o = 0, if_id_we_o = 0, freeze_o = 1, all other strobes 0, pc_sel_o = 00. start_i = 1 → RUN next cycle.
- start_i = 0 in RUN or MULT → IDLE next cycle, multiply counter cleared; outputs that cycle still follow the current state.
- RUN, first matching rule wins (all outputs combinational from state + inputs):
  - mem_stall_i: freeze_o = 1, pc_we_o = 0, if_id_we_o = 0; stay RUN.
  - mult_start_i: same as mem stall; load mult counter with MUL_LATENCY−1; → MULT.
  - ld_use_hazard_i: pc_we_o = 0, if_id_we_o = 0, id_ex_bubble_o = 1, freeze_o = 0.
  - jump_i: pc_we_o = 1, pc_sel_o = 10, if_id_flush_o = 1.
  - branch_taken_i: pc_we_o = 1, pc_sel_o = 01, if_id_flush_o = 1.
  - otherwise: pc_we_o = 1, if_id_we_o = 1, pc_sel_o = 00.
- MULT: mult_start_i ignored. Counter ≠ 0: full freeze, counter decrements. Counter = 0 and mem_stall_i = 0: outputs as RUN rules excluding mult_start_i; → RUN. Counter = 0 and mem_stall_i = 1: full freeze, stay MULT.
- stall_cnt_o: increments in RUN/MULT on every cycle with pc_we_o = 0; holds at all-ones; held in IDLE; cleared only by reset.

## Timing
- All strobes are same-cycle combinational; the PC and pipeline registers sample them at the next rising edge.
- Load-use: exactly one bubble per asserted cycle; bench hazard logic deasserts once the load reaches MEM.
- Multiply: mult_start_i first seen at cycle T → freeze T…T+MUL_LATENCY−1, advance at T+MUL_LATENCY (no mem stall). MUL_LATENCY = 1 → single-cycle freeze.
- Branch + load-use in the same cycle: stall wins, branch re-evaluated next cycle. Jump + branch: jump wins.
- Reset asserted mid-MULT: immediate IDLE outputs, counter values lost.

## Structure
- Shared package: state encoding (IDLE/RUN/MULT) and PC_SEL_SEQ/BRANCH/JUMP constants; the ID-stage next-PC mux uses the same constants.
- One sub-module: sat_counter (parameterised width, enable, async active-low clear) for stall_cnt_o.
- Multiply down-counter and FSM inline.

## Test plan
- Reset, start_i = 1 at cycle 2 → IDLE outputs (freeze_o = 1, pc_we_o = 0) until the edge after start; then pc_we_o = 1, pc_sel_o = 00 each cycle.
- ld_use_hazard_i one cycle with branch_taken_i also high → pc_we_o = 0, id_ex_bubble_o = 1, if_id_flush_o = 0; next cycle branch alone → pc_sel_o = 01, if_id_flush_o = 1; stall_cnt_o = 1.
- mult_start_i held 4 cycles, MUL_LATENCY = 3 → freeze_o = 1 for exactly 3 cycles, mult_busy_o high cycles 2–4, pc_we_o = 1 on cycle 4; stall_cnt_o = 3.
- mem_stall_i rises during MULT at counter = 1 and holds 3 cycles → freeze extends until mem_stall_i falls; release the same cycle it falls.
- start_i dropped mid-MULT → IDLE next cycle; restart → mult_start_i re-triggers a full MUL_LATENCY freeze.
- CNT_W = 4, 20 load-use cycles → stall_cnt_o saturates at 15; rst_i low asynchronously mid-clock → stall_cnt_o = 0 and IDLE outputs immediately.
